// File: rtl/dump_ctrl.sv
// dump_ctrl
//   Streams one channel's capture RAM out through a byte UART. A dump starts
//   at the oldest sample (trig_pos) and walks the circular buffer, sending
//   exactly DEPTH bytes.
//
//   Byte loop: READ (issue RAM read) -> LATCH (capture read data, strobe
//   trmt) -> WAIT_TX (hold tx_data until tx_done).
//   After the last byte, DONE pulses dump_finished for one cycle and the
//   FSM returns to IDLE.
//
// Ports
//   clk           : system clock, rising edge
//   rst_n         : synchronous active-low reset
//   dump_start    : single-cycle dump request (ignored while busy)
//   dump_chan     : channel to dump, 01/10/11 = CH1/CH2/CH3, 00 = invalid
//   trig_pos      : address of the oldest sample; out-of-range maps to 0
//   read_data     : muxed RAM data, valid one clk after dump_en/addr
//   tx_done       : UART byte-complete pulse (honoured only in WAIT_TX)
//   dump_en       : RAM read enable, high only in READ
//   ch_sel        : RAM read mux select, held after a dump completes
//   addr          : RAM read address, always in 0..DEPTH-1
//   tx_data       : byte presented to the UART
//   trmt          : UART transmit strobe, high only in LATCH
//   busy          : high whenever the FSM is not IDLE
//   dump_finished : single-cycle pulse after the last byte is sent
module dump_ctrl #(
  parameter int unsigned DEPTH = 384,
  parameter int unsigned AW    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dump_start,
  input  logic [1:0]    dump_chan,
  input  logic [AW-1:0] trig_pos,
  input  logic [7:0]    read_data,
  input  logic          tx_done,
  output logic          dump_en,
  output logic [1:0]    ch_sel,
  output logic [AW-1:0] addr,
  output logic [7:0]    tx_data,
  output logic          trmt,
  output logic          busy,
  output logic          dump_finished
);

  // Byte counter must hold DEPTH itself without wrapping.
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(DEPTH - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
  // One extra bit so the range test still works when DEPTH == 2**AW.
  localparam logic [AW:0]   DEPTH_X   = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    WAIT_TX,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    ch_sel_q, ch_sel_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;

  logic [AW-1:0] start_addr;
  logic [AW-1:0] addr_next;

  // Out-of-range trigger positions restart the walk at the bottom.
  always_comb begin
    start_addr = '0;
    if ({1'b0, trig_pos} < DEPTH_X) begin
      start_addr = trig_pos;
    end
  end

  // Circular increment over 0..DEPTH-1.
  always_comb begin
    addr_next = addr_q + 1'b1;
    if (addr_q == ADDR_LAST) begin
      addr_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_sel_q  <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ch_sel_q  <= ch_sel_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_sel_d  = ch_sel_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;

    unique case (state_q)
      IDLE: begin
        if (dump_start && (dump_chan != 2'b00)) begin
          ch_sel_d = dump_chan;
          addr_d   = start_addr;
          cnt_d    = '0;
          state_d  = READ;
        end
      end

      READ: begin
        state_d = LATCH;
      end

      LATCH: begin
        tx_data_d = read_data;
        state_d   = WAIT_TX;
      end

      WAIT_TX: begin
        if (tx_done) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_next;
            state_d = READ;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs: pure decodes of the registered state.
  assign dump_en       = (state_q == READ);
  assign trmt          = (state_q == LATCH);
  assign busy          = (state_q != IDLE);
  assign dump_finished = (state_q == DONE);

  assign ch_sel  = ch_sel_q;
  assign addr    = addr_q;
  assign tx_data = tx_data_q;

endmodule

// File: tb/tb_dump_ctrl.sv
// Testbench for dump_ctrl with DEPTH=8, AW=4.
// A registered RAM model feeds read_data and a UART model answers each trmt
// with a tx_done a programmable number of cycles later.
module tb_dump_ctrl;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 4;

  logic          clk;
  logic          rst_n;
  logic          dump_start;
  logic [1:0]    dump_chan;
  logic [AW-1:0] trig_pos;
  logic [7:0]    read_data;
  logic          tx_done;
  logic          dump_en;
  logic [1:0]    ch_sel;
  logic [AW-1:0] addr;
  logic [7:0]    tx_data;
  logic          trmt;
  logic          busy;
  logic          dump_finished;

  dump_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dump_start    (dump_start),
    .dump_chan     (dump_chan),
    .trig_pos      (trig_pos),
    .read_data     (read_data),
    .tx_done       (tx_done),
    .dump_en       (dump_en),
    .ch_sel        (ch_sel),
    .addr          (addr),
    .tx_data       (tx_data),
    .trmt          (trmt),
    .busy          (busy),
    .dump_finished (dump_finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // RAM contents: distinct per channel and address.
  function automatic logic [7:0] ram_byte(input logic [1:0] ch, input logic [3:0] a);
    return {ch, 2'b10, a} ^ 8'h35;
  endfunction

  initial read_data = 8'h00;
  always @(posedge clk) begin
    if (dump_en) read_data <= ram_byte(ch_sel, addr);
  end

  // UART model: tx_done is seen by the DUT tx_dly cycles after the trmt cycle.
  int unsigned tx_dly = 4;
  int unsigned cd     = 0;
  logic        uart_done  = 1'b0;
  logic        extra_done = 1'b0;
  assign tx_done = uart_done | extra_done;

  always @(negedge clk) begin
    uart_done = 1'b0;
    if (!busy) begin
      cd = 0;
    end else begin
      if (cd != 0) begin
        cd--;
        if (cd == 0) uart_done = 1'b1;
      end
      if (trmt) cd = tx_dly;
    end
  end

  // Monitor: logs every read address/channel and the byte following each trmt.
  logic [3:0]  addr_log[$];
  logic [1:0]  ch_log[$];
  logic [7:0]  txd_log[$];
  int unsigned n_trmt = 0;
  int unsigned n_fin  = 0;
  bit          pend   = 1'b0;

  always @(negedge clk) begin
    if (pend) begin
      txd_log.push_back(tx_data);
      pend = 1'b0;
    end
    if (dump_en) begin
      addr_log.push_back(addr);
      ch_log.push_back(ch_sel);
    end
    if (trmt) begin
      n_trmt++;
      pend = 1'b1;
    end
    if (dump_finished) n_fin++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Called on a negedge; returns on the negedge of cycle 0 (state READ).
  task automatic start_dump(input logic [1:0] ch, input logic [3:0] tp);
    dump_start = 1'b1;
    dump_chan  = ch;
    trig_pos   = tp;
    @(negedge clk);
    dump_start = 1'b0;
    dump_chan  = 2'b00;
  endtask

  task automatic wait_idle(input string tag, output int unsigned cycles, output int unsigned fin_at);
    cycles = 0;
    fin_at = 0;
    while (busy && cycles < 1000) begin
      if (dump_finished) fin_at = cycles;
      @(negedge clk);
      cycles++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_dump(input string tag, input int ba, input int bx, input int unsigned bt,
                            input int unsigned bf, input logic [3:0] first, input logic [1:0] ch);
    check({tag, "_nread"}, 32'(addr_log.size() - ba), 32'd8);
    check({tag, "_ntrmt"}, n_trmt - bt, 32'd8);
    check({tag, "_nfin"},  n_fin - bf, 32'd1);
    for (int i = 0; i < 8; i++) begin
      int unsigned ai;
      logic [3:0]  ea;
      ai = (32'(first) + 32'(i)) % 8;
      ea = ai[3:0];
      if (ba + i < addr_log.size()) begin
        check($sformatf("%s_addr%0d", tag, i), 32'(addr_log[ba+i]), 32'(ea));
        check($sformatf("%s_ch%0d", tag, i), 32'(ch_log[ba+i]), 32'(ch));
      end
      if (bx + i < txd_log.size()) begin
        check($sformatf("%s_txd%0d", tag, i), 32'(txd_log[bx+i]), 32'(ram_byte(ch, ea)));
      end
    end
    check({tag, "_chsel_hold"}, 32'(ch_sel), 32'(ch));
  endtask

  typedef struct {
    logic [1:0]  chan;
    logic [3:0]  trig;
    int unsigned dly;
    bit          spur;
    logic [3:0]  exp_first;
    logic [1:0]  exp_ch;
    int unsigned exp_cycles;
  } vec_t;

  localparam int NV = 5;
  vec_t vec[NV];

  initial begin
    int unsigned cyc, fin_at, off, k, guard;
    int          ba, bx;
    int unsigned bt, bf;
    bit          saw_busy;

    //          chan   trig  dly spur first  ch     cycles (8*(2+dly)+1)
    vec[0] = '{2'b10, 4'd5,  4, 1, 4'd5, 2'b10, 49};
    vec[1] = '{2'b11, 4'd9,  2, 0, 4'd0, 2'b11, 33};
    vec[2] = '{2'b01, 4'd7,  1, 0, 4'd7, 2'b01, 25};
    vec[3] = '{2'b10, 4'd15, 3, 0, 4'd0, 2'b10, 41};
    vec[4] = '{2'b11, 4'd0,  1, 1, 4'd0, 2'b11, 25};

    rst_n      = 1'b0;
    dump_start = 1'b0;
    dump_chan  = 2'b00;
    trig_pos   = '0;
    repeat (2) @(negedge clk);

    check("rst_busy",    32'(busy),          32'd0);
    check("rst_dump_en", 32'(dump_en),       32'd0);
    check("rst_trmt",    32'(trmt),          32'd0);
    check("rst_fin",     32'(dump_finished), 32'd0);
    check("rst_chsel",   32'(ch_sel),        32'd0);
    check("rst_addr",    32'(addr),          32'd0);
    check("rst_txdata",  32'(tx_data),       32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      string tag;
      tag    = $sformatf("v%0d", v);
      tx_dly = vec[v].dly;
      ba = addr_log.size();
      bx = txd_log.size();
      bt = n_trmt;
      bf = n_fin;
      start_dump(vec[v].chan, vec[v].trig);
      off = 0;
      if (vec[v].spur) begin
        // Competing request mid-dump must not disturb channel or sequence.
        repeat (5) @(negedge clk);
        dump_start = 1'b1;
        dump_chan  = 2'b01;
        trig_pos   = 4'd2;
        @(negedge clk);
        dump_start = 1'b0;
        dump_chan  = 2'b00;
        off = 6;
      end
      wait_idle(tag, cyc, fin_at);
      check({tag, "_cycles"}, cyc + off, vec[v].exp_cycles);
      check({tag, "_fin_at"}, fin_at + off, vec[v].exp_cycles - 1);
      check_dump(tag, ba, bx, bt, bf, vec[v].exp_first, vec[v].exp_ch);
      repeat (2) @(negedge clk);
    end

    // Invalid channel plus a stray tx_done while idle: nothing may move.
    bt = n_trmt;
    ba = addr_log.size();
    saw_busy   = 1'b0;
    dump_start = 1'b1;
    dump_chan  = 2'b00;
    trig_pos   = 4'd3;
    extra_done = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    extra_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (busy) saw_busy = 1'b1;
      @(negedge clk);
    end
    check("inv_busy",  32'(saw_busy), 32'd0);
    check("inv_trmt",  n_trmt - bt, 32'd0);
    check("inv_read",  32'(addr_log.size() - ba), 32'd0);
    check("inv_chsel", 32'(ch_sel), 32'(2'b11));
    check("inv_addr",  32'(addr), 32'd7);

    // Reset after the third byte's strobe, then an immediate new dump.
    tx_dly = 2;
    bf = n_fin;
    start_dump(2'b11, 4'd6);
    k = 0;
    guard = 0;
    while (k < 3 && guard < 200) begin
      if (trmt) k++;
      if (k < 3) begin
        @(negedge clk);
        guard++;
      end
    end
    check("rst3_reach", k, 32'd3);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy",   32'(busy),          32'd0);
    check("mid_rst_addr",   32'(addr),          32'd0);
    check("mid_rst_chsel",  32'(ch_sel),        32'd0);
    check("mid_rst_txdata", 32'(tx_data),       32'd0);
    check("mid_rst_fin",    32'(dump_finished), 32'd0);
    check("mid_rst_nfin",   n_fin - bf,         32'd0);
    ba = addr_log.size();
    bx = txd_log.size();
    bt = n_trmt;
    rst_n = 1'b1;
    start_dump(2'b10, 4'd1);
    check("post_rst_busy", 32'(busy), 32'd1);
    wait_idle("post_rst", cyc, fin_at);
    check("post_rst_cycles", cyc, 32'd33);
    check_dump("post_rst", ba, bx, bt, bf, 4'd1, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
